// File: rtl/forwarding_scoreboard_pkg.sv
// Shared constants and index helpers for the VTX1 operand bypass unit.
// Select encoding: 0 = register file, 1 = load return, 2 and up = bypass lanes.
package vtx1_fwd_pkg;

    localparam int unsigned FWD_SEL_RF   = 32'd0;
    localparam int unsigned FWD_SEL_RET  = 32'd1;
    localparam int unsigned FWD_SEL_BYP0 = 32'd2;

    function automatic int sel_width(input int num_stages, input int num_lanes);
        return $clog2(32'd2 + num_stages * num_lanes);
    endfunction

    // Flattened lane index; ascending index is also descending bypass priority.
    function automatic int byp_idx(input int s, input int l, input int num_lanes);
        return s * num_lanes + l;
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_fwd_operand_mux.sv
// Per-operand source selector: load return, then bypass lanes, then register file.
module fwd_operand_mux
    import vtx1_fwd_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int NUM_LANES  = 2,
    parameter int WORD_W     = 32,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = 3
) (
    input  logic                                   dec_valid,
    input  logic [REG_AW-1:0]                      src,
    input  logic                                   src_pending,
    input  logic [WORD_W-1:0]                      rf_data,
    input  logic [NUM_STAGES*NUM_LANES-1:0]        byp_valid,
    input  logic [NUM_STAGES*NUM_LANES*REG_AW-1:0] byp_rd,
    input  logic [NUM_STAGES*NUM_LANES*WORD_W-1:0] byp_data,
    input  logic                                   ld_ret_valid,
    input  logic [REG_AW-1:0]                      ld_ret_rd,
    input  logic [WORD_W-1:0]                      ld_ret_data,
    output logic [WORD_W-1:0]                      fwd_data,
    output logic [SEL_W-1:0]                       fwd_sel,
    output logic                                   stall
);

    logic ret_hit_s;
    logic byp_hit_s;

    // Priority resolution; a pending load stalls unless its data arrives this cycle.
    always_comb begin
        fwd_data  = rf_data;
        fwd_sel   = SEL_W'(FWD_SEL_RF);
        stall     = 1'b0;
        byp_hit_s = 1'b0;
        ret_hit_s = ld_ret_valid && (ld_ret_rd == src);
        if (dec_valid && (src != '0)) begin
            if (ret_hit_s) begin
                fwd_data = ld_ret_data;
                fwd_sel  = SEL_W'(FWD_SEL_RET);
            end else if (src_pending) begin
                stall = 1'b1;
            end else begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (!byp_hit_s && byp_valid[byp_idx(s, l, NUM_LANES)] &&
                            (byp_rd[byp_idx(s, l, NUM_LANES)*REG_AW +: REG_AW] == src)) begin
                            byp_hit_s = 1'b1;
                            fwd_data  = byp_data[byp_idx(s, l, NUM_LANES)*WORD_W +: WORD_W];
                            fwd_sel   = SEL_W'(FWD_SEL_BYP0 + byp_idx(s, l, NUM_LANES));
                        end else begin
                            byp_hit_s = byp_hit_s;
                        end
                    end
                end
            end
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand bypass unit with a per-register pending-load scoreboard, load timeout
// watchdog and saturating performance counters.
module forwarding_scoreboard
    import vtx1_fwd_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int NUM_STAGES   = 2,
    parameter int NUM_LANES    = 2,
    parameter int WORD_W       = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32,
    parameter int SEL_W        = sel_width(NUM_STAGES, NUM_LANES)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   dec_valid,
    input  logic [NUM_SRC*REG_AW-1:0]              dec_src,
    input  logic [NUM_SRC*WORD_W-1:0]              rf_data,
    input  logic [NUM_STAGES*NUM_LANES-1:0]        byp_valid,
    input  logic [NUM_STAGES*NUM_LANES*REG_AW-1:0] byp_rd,
    input  logic [NUM_STAGES*NUM_LANES*WORD_W-1:0] byp_data,
    input  logic                                   ld_issue_valid,
    input  logic [REG_AW-1:0]                      ld_issue_rd,
    output logic                                   ld_issue_ready,
    input  logic                                   ld_ret_valid,
    input  logic [REG_AW-1:0]                      ld_ret_rd,
    input  logic [WORD_W-1:0]                      ld_ret_data,
    output logic [NUM_SRC*WORD_W-1:0]              fwd_data,
    output logic [NUM_SRC*SEL_W-1:0]               fwd_sel,
    output logic [NUM_SRC-1:0]                     stall_src,
    output logic                                   stall,
    output logic [2**REG_AW-1:0]                   pending_vec,
    output logic                                   load_timeout,
    output logic [REG_AW-1:0]                      timeout_rd,
    output logic [CNT_W-1:0]                       cnt_bypass,
    output logic [CNT_W-1:0]                       cnt_ret_fwd,
    output logic [CNT_W-1:0]                       cnt_stall
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int TMR_W    = 8;

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [TMR_W-1:0]    tmr_q [NUM_REGS];
    logic [TMR_W-1:0]    tmr_d [NUM_REGS];
    logic [NUM_REGS-1:0] expire_s;
    logic                timeout_q, timeout_d;
    logic [REG_AW-1:0]   trd_q, trd_d;
    logic [CNT_W-1:0]    cnt_byp_q, cnt_byp_d;
    logic [CNT_W-1:0]    cnt_ret_q, cnt_ret_d;
    logic [CNT_W-1:0]    cnt_stall_q, cnt_stall_d;
    logic [NUM_SRC-1:0]  any_byp_s, any_ret_s;
    logic                issue_acc_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_opnd
        fwd_operand_mux #(
            .NUM_STAGES (NUM_STAGES),
            .NUM_LANES  (NUM_LANES),
            .WORD_W     (WORD_W),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_mux (
            .dec_valid    (dec_valid),
            .src          (dec_src[i*REG_AW +: REG_AW]),
            .src_pending  (pend_q[dec_src[i*REG_AW +: REG_AW]]),
            .rf_data      (rf_data[i*WORD_W +: WORD_W]),
            .byp_valid    (byp_valid),
            .byp_rd       (byp_rd),
            .byp_data     (byp_data),
            .ld_ret_valid (ld_ret_valid),
            .ld_ret_rd    (ld_ret_rd),
            .ld_ret_data  (ld_ret_data),
            .fwd_data     (fwd_data[i*WORD_W +: WORD_W]),
            .fwd_sel      (fwd_sel[i*SEL_W +: SEL_W]),
            .stall        (stall_src[i])
        );
        assign any_byp_s[i] = (fwd_sel[i*SEL_W +: SEL_W] >= SEL_W'(FWD_SEL_BYP0));
        assign any_ret_s[i] = (fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(FWD_SEL_RET));
    end

    // A same-cycle return to the issued register frees the slot for the new load.
    assign ld_issue_ready = !flush &&
                            (!pend_q[ld_issue_rd] || (ld_ret_valid && (ld_ret_rd == ld_issue_rd)));
    assign issue_acc_s    = ld_issue_valid && ld_issue_ready && (ld_issue_rd != '0);
    assign stall          = |stall_src;
    assign pending_vec    = pend_q;
    assign load_timeout   = timeout_q;
    assign timeout_rd     = trd_q;
    assign cnt_bypass     = cnt_byp_q;
    assign cnt_ret_fwd    = cnt_ret_q;
    assign cnt_stall      = cnt_stall_q;

    // Scoreboard next state: return/expiry clear, then issue overrides, then flush.
    always_comb begin
        pend_d   = pend_q;
        tmr_d    = tmr_q;
        expire_s = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (pend_q[r]) begin
                if (ld_ret_valid && (ld_ret_rd == REG_AW'(r))) begin
                    pend_d[r] = 1'b0;
                    tmr_d[r]  = '0;
                end else if (tmr_q[r] == TMR_W'(1)) begin
                    pend_d[r]   = 1'b0;
                    tmr_d[r]    = '0;
                    expire_s[r] = 1'b1;
                end else begin
                    tmr_d[r] = tmr_q[r] - TMR_W'(1);
                end
            end else begin
                tmr_d[r] = tmr_q[r];
            end
        end
        if (issue_acc_s) begin
            pend_d[ld_issue_rd] = 1'b1;
            tmr_d[ld_issue_rd]  = TMR_W'(LOAD_TIMEOUT);
        end else begin
            pend_d = pend_d;
        end
        if (flush) begin
            pend_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tmr_d[r] = '0;
            end
        end else begin
            pend_d = pend_d;
        end
    end

    // Sticky timeout; descending scan leaves the lowest expiring register captured.
    always_comb begin
        timeout_d = timeout_q | (|expire_s);
        trd_d     = trd_q;
        if (!timeout_q) begin
            for (int r = NUM_REGS - 1; r > 0; r--) begin
                if (expire_s[r]) begin
                    trd_d = REG_AW'(r);
                end else begin
                    trd_d = trd_d;
                end
            end
        end else begin
            trd_d = trd_q;
        end
    end

    // Saturating counters; stalled bundles only advance the stall counter.
    always_comb begin
        cnt_byp_d   = cnt_byp_q;
        cnt_ret_d   = cnt_ret_q;
        cnt_stall_d = cnt_stall_q;
        if (dec_valid && !stall) begin
            if ((|any_byp_s) && (cnt_byp_q != '1)) begin
                cnt_byp_d = cnt_byp_q + CNT_W'(1);
            end else begin
                cnt_byp_d = cnt_byp_q;
            end
            if ((|any_ret_s) && (cnt_ret_q != '1)) begin
                cnt_ret_d = cnt_ret_q + CNT_W'(1);
            end else begin
                cnt_ret_d = cnt_ret_q;
            end
        end else if (dec_valid && (cnt_stall_q != '1)) begin
            cnt_stall_d = cnt_stall_q + CNT_W'(1);
        end else begin
            cnt_stall_d = cnt_stall_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tmr_q[r] <= '0;
            end
            timeout_q   <= 1'b0;
            trd_q       <= '0;
            cnt_byp_q   <= '0;
            cnt_ret_q   <= '0;
            cnt_stall_q <= '0;
        end else begin
            pend_q      <= pend_d;
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
            trd_q       <= trd_d;
            cnt_byp_q   <= cnt_byp_d;
            cnt_ret_q   <= cnt_ret_d;
            cnt_stall_q <= cnt_stall_d;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard with LOAD_TIMEOUT=4 and 4-bit counters.
module tb_forwarding_scoreboard;

    localparam int NUM_SRC    = 3;
    localparam int NUM_STAGES = 2;
    localparam int NUM_LANES  = 2;
    localparam int WORD_W     = 32;
    localparam int REG_AW     = 5;
    localparam int CNT_W      = 4;
    localparam int SEL_W      = 3;
    localparam int NB         = NUM_STAGES * NUM_LANES;

    logic                          clk = 1'b0;
    logic                          rst_n, flush, dec_valid;
    logic [NUM_SRC*REG_AW-1:0]     dec_src;
    logic [NUM_SRC*WORD_W-1:0]     rf_data;
    logic [NB-1:0]                 byp_valid;
    logic [NB*REG_AW-1:0]          byp_rd;
    logic [NB*WORD_W-1:0]          byp_data;
    logic                          ld_issue_valid, ld_issue_ready, ld_ret_valid;
    logic [REG_AW-1:0]             ld_issue_rd, ld_ret_rd, timeout_rd;
    logic [WORD_W-1:0]             ld_ret_data;
    logic [NUM_SRC*WORD_W-1:0]     fwd_data;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic [NUM_SRC-1:0]            stall_src;
    logic                          stall, load_timeout;
    logic [31:0]                   pending_vec;
    logic [CNT_W-1:0]              cnt_bypass, cnt_ret_fwd, cnt_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard #(
        .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .NUM_LANES(NUM_LANES), .WORD_W(WORD_W),
        .REG_AW(REG_AW), .LOAD_TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dec_valid(dec_valid), .dec_src(dec_src),
        .rf_data(rf_data), .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_ret_valid(ld_ret_valid), .ld_ret_rd(ld_ret_rd), .ld_ret_data(ld_ret_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall_src(stall_src), .stall(stall),
        .pending_vec(pending_vec), .load_timeout(load_timeout), .timeout_rd(timeout_rd),
        .cnt_bypass(cnt_bypass), .cnt_ret_fwd(cnt_ret_fwd), .cnt_stall(cnt_stall)
    );

    task automatic clear_inputs();
        flush = 1'b0; dec_valid = 1'b0; dec_src = '0;
        rf_data = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
        byp_valid = '0; byp_rd = '0; byp_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0;
        ld_ret_valid = 1'b0; ld_ret_rd = '0; ld_ret_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byp(input int idx, input logic [4:0] rd, input logic [31:0] data);
        byp_valid[idx]             = 1'b1;
        byp_rd[idx*REG_AW +: REG_AW] = rd;
        byp_data[idx*WORD_W +: WORD_W] = data;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending_vec); end
        checks++; if ({load_timeout, timeout_rd} !== 6'h0) begin errors++; $display("FAIL reset_timeout got %b/%0d want 0/0", load_timeout, timeout_rd); end
        checks++; if ({cnt_bypass, cnt_ret_fwd, cnt_stall} !== 12'h0) begin errors++; $display("FAIL reset_counters got %h want 000", {cnt_bypass, cnt_ret_fwd, cnt_stall}); end
        checks++; if (ld_issue_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL reset_ready_stall got %b/%b want 1/0", ld_issue_ready, stall); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_bypass();
        clear_inputs();
        dec_valid = 1'b1;
        dec_src = {5'd0, 5'd6, 5'd5};
        set_byp(1, 5'd5, 32'h0000_AAAA);
        set_byp(2, 5'd6, 32'h0000_BBBB);
        #1;
        checks++; if (fwd_sel !== {3'd0, 3'd4, 3'd3}) begin errors++; $display("FAIL basic_sel got %h want %h", fwd_sel, {3'd0, 3'd4, 3'd3}); end
        checks++; if (fwd_data !== {32'h0000_0102, 32'h0000_BBBB, 32'h0000_AAAA}) begin errors++; $display("FAIL basic_data got %h", fwd_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_stall got %b want 0", stall); end
        step();
        clear_inputs();
        checks++; if (cnt_bypass !== 4'd1 || cnt_ret_fwd !== 4'd0) begin errors++; $display("FAIL basic_cnt got %0d/%0d want 1/0", cnt_bypass, cnt_ret_fwd); end
    endtask

    task automatic test_bypass_priority();
        clear_inputs();
        dec_valid = 1'b1;
        dec_src = {5'd0, 5'd0, 5'd7};
        set_byp(0, 5'd7, 32'h0000_0070);
        set_byp(1, 5'd7, 32'h0000_0071);
        set_byp(2, 5'd7, 32'h0000_0072);
        #1;
        checks++; if (fwd_sel !== {3'd0, 3'd0, 3'd2}) begin errors++; $display("FAIL prio_sel got %h want %h", fwd_sel, {3'd0, 3'd0, 3'd2}); end
        checks++; if (fwd_data[31:0] !== 32'h0000_0070) begin errors++; $display("FAIL prio_data got %h want 00000070", fwd_data[31:0]); end
        step();
        clear_inputs();
        checks++; if (cnt_bypass !== 4'd2) begin errors++; $display("FAIL prio_cnt got %0d want 2", cnt_bypass); end
    endtask

    task automatic test_load_stall();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        #1;
        checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b want 1", ld_issue_ready); end
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0000_0200) begin errors++; $display("FAIL ld_pending_set got %h want 00000200", pending_vec); end
        dec_valid = 1'b1; dec_src = {5'd0, 5'd0, 5'd9};
        set_byp(0, 5'd9, 32'h0000_0099);
        #1;
        checks++; if (stall !== 1'b1 || stall_src !== 3'b001) begin errors++; $display("FAIL ld_stall got %b/%b want 1/001", stall, stall_src); end
        checks++; if (fwd_sel !== 9'h0 || fwd_data[31:0] !== 32'h0000_0100) begin errors++; $display("FAIL ld_stall_sel got %h/%h want 0/00000100", fwd_sel, fwd_data[31:0]); end
        step();
        clear_inputs();
        checks++; if (cnt_stall !== 4'd1 || cnt_bypass !== 4'd2) begin errors++; $display("FAIL ld_stall_cnt got %0d/%0d want 1/2", cnt_stall, cnt_bypass); end
        step();
        dec_valid = 1'b1; dec_src = {5'd0, 5'd0, 5'd9};
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd9; ld_ret_data = 32'h0000_1234;
        #1;
        checks++; if (stall !== 1'b0 || fwd_sel !== {3'd0, 3'd0, 3'd1}) begin errors++; $display("FAIL ret_fwd_sel got %b/%h want 0/001", stall, fwd_sel); end
        checks++; if (fwd_data[31:0] !== 32'h0000_1234 || pending_vec !== 32'h0000_0200) begin errors++; $display("FAIL ret_fwd_data got %h/%h want 00001234/00000200", fwd_data[31:0], pending_vec); end
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL ret_clear got %h want 0", pending_vec); end
        checks++; if (cnt_ret_fwd !== 4'd1 || cnt_stall !== 4'd1) begin errors++; $display("FAIL ret_cnt got %0d/%0d want 1/1", cnt_ret_fwd, cnt_stall); end
    endtask

    task automatic test_ret_priority();
        clear_inputs();
        dec_valid = 1'b1; dec_src = {5'd0, 5'd0, 5'd8};
        set_byp(0, 5'd8, 32'h0000_0080);
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd8; ld_ret_data = 32'h0000_0088;
        #1;
        checks++; if (fwd_sel !== {3'd0, 3'd0, 3'd1} || fwd_data[31:0] !== 32'h0000_0088) begin errors++; $display("FAIL retprio got %h/%h want 001/00000088", fwd_sel, fwd_data[31:0]); end
        step();
        clear_inputs();
        checks++; if (cnt_ret_fwd !== 4'd2 || cnt_bypass !== 4'd2 || pending_vec !== 32'h0) begin errors++; $display("FAIL retprio_state got %0d/%0d/%h want 2/2/0", cnt_ret_fwd, cnt_bypass, pending_vec); end
    endtask

    task automatic test_reissue();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        step();
        #1;
        checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("FAIL reissue_busy got %b want 0", ld_issue_ready); end
        step();
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd9; ld_ret_data = 32'h0000_5555;
        #1;
        checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("FAIL reissue_ret_ready got %b want 1", ld_issue_ready); end
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0000_0200) begin errors++; $display("FAIL reissue_pending got %h want 00000200", pending_vec); end
        step(); step(); step();
        checks++; if (pending_vec !== 32'h0000_0200 || load_timeout !== 1'b0) begin errors++; $display("FAIL reissue_reload got %h/%b want 00000200/0", pending_vec, load_timeout); end
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd9;
        step();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0 || load_timeout !== 1'b0) begin errors++; $display("FAIL issue_r0 got %h/%b want 0/0", pending_vec, load_timeout); end
    endtask

    task automatic test_timeout();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
        step();
        clear_inputs();
        step(); step(); step();
        checks++; if (pending_vec !== 32'h0000_1000 || load_timeout !== 1'b0) begin errors++; $display("FAIL to_before got %h/%b want 00001000/0", pending_vec, load_timeout); end
        step();
        checks++; if (pending_vec !== 32'h0 || load_timeout !== 1'b1 || timeout_rd !== 5'd12) begin errors++; $display("FAIL to_fire got %h/%b/%0d want 0/1/12", pending_vec, load_timeout, timeout_rd); end
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd11;
        step();
        clear_inputs();
        step(); step(); step(); step();
        checks++; if (pending_vec !== 32'h0 || timeout_rd !== 5'd12) begin errors++; $display("FAIL to_first_only got %h/%0d want 0/12", pending_vec, timeout_rd); end
        flush = 1'b1;
        #1;
        checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ld_issue_ready); end
        step();
        clear_inputs();
        checks++; if (load_timeout !== 1'b1 || timeout_rd !== 5'd12) begin errors++; $display("FAIL to_sticky got %b/%0d want 1/12", load_timeout, timeout_rd); end
    endtask

    task automatic test_flush();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
        step();
        ld_issue_rd = 5'd4;
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0000_0018) begin errors++; $display("FAIL flush_pre got %h want 00000018", pending_vec); end
        flush = 1'b1; ld_issue_valid = 1'b1; ld_issue_rd = 5'd5;
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL flush_clear got %h want 0", pending_vec); end
        checks++; if (cnt_bypass !== 4'd2 || cnt_ret_fwd !== 4'd2 || cnt_stall !== 4'd1) begin errors++; $display("FAIL flush_cnt got %0d/%0d/%0d want 2/2/1", cnt_bypass, cnt_ret_fwd, cnt_stall); end
    endtask

    task automatic test_back_to_back_saturation();
        clear_inputs();
        dec_valid = 1'b1; dec_src = {5'd0, 5'd0, 5'd5};
        set_byp(0, 5'd5, 32'h0000_0055);
        for (int n = 0; n < 20; n++) begin
            step();
        end
        clear_inputs();
        checks++; if (cnt_bypass !== 4'd15) begin errors++; $display("FAIL sat_bypass got %0d want 15", cnt_bypass); end
        checks++; if (cnt_ret_fwd !== 4'd2 || cnt_stall !== 4'd1) begin errors++; $display("FAIL sat_others got %0d/%0d want 2/1", cnt_ret_fwd, cnt_stall); end
    endtask

    task automatic test_reset_mid_load();
        clear_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd20;
        step();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (pending_vec !== 32'h0 || load_timeout !== 1'b0 || cnt_bypass !== 4'd0) begin errors++; $display("FAIL rst_mid got %h/%b/%0d want 0/0/0", pending_vec, load_timeout, cnt_bypass); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd20;
        step();
        clear_inputs();
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL rst_late_ret got %h want 0", pending_vec); end
    endtask

    initial begin
        test_reset();
        test_basic_bypass();
        test_bypass_priority();
        test_load_stall();
        test_ret_priority();
        test_reissue();
        test_timeout();
        test_flush();
        test_back_to_back_saturation();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised next-generation operand bypass unit for the VTX1 VLIW pipeline.
- Resolves RAW hazards for NUM_SRC decode operands against NUM_STAGES x NUM_LANES in-flight results.
- Adds a per-register pending-load scoreboard with variable-latency load return and a timeout watchdog, replacing fixed "load in execute" stalling.
- Sits between register file read and execute operand latches; drives the decode stall.

Parameters:
NUM_SRC, 3, decode source operands per bundle
NUM_STAGES, 2, bypass stages; stage 0 is youngest
NUM_LANES, 2, write lanes per bypass stage
WORD_W, 32, data width
REG_AW, 5, register address width; register 0 is hard-wired zero
LOAD_TIMEOUT, 16, maximum cycles a load may stay pending; range 2..255
CNT_W, 32, performance counter width
SEL_W, derived as clog2(2+NUM_STAGES*NUM_LANES), width of each select field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; clears the scoreboard
dec_valid  in  1  decode bundle valid
dec_src  in  NUM_SRC*REG_AW  source register addresses, operand i at slice i
rf_data  in  NUM_SRC*WORD_W  register file read data
byp_valid  in  NUM_STAGES*NUM_LANES  lane write enable qualified by stage valid; index s*NUM_LANES+l
byp_rd  in  NUM_STAGES*NUM_LANES*REG_AW  lane destination register
byp_data  in  NUM_STAGES*NUM_LANES*WORD_W  lane result
ld_issue_valid  in  1  load issued to memory
ld_issue_rd  in  REG_AW  load destination register
ld_issue_ready  out  1  scoreboard accepts the issue
ld_ret_valid  in  1  load data returned
ld_ret_rd  in  REG_AW  returned load destination
ld_ret_data  in  WORD_W  returned load data
fwd_data  out  NUM_SRC*WORD_W  resolved operands
fwd_sel  out  NUM_SRC*SEL_W  per-operand source: 0=RF, 1=load return, 2+s*NUM_LANES+l=bypass lane
stall_src  out  NUM_SRC  per-operand pending-load hazard
stall  out  1  OR of stall_src
pending_vec  out  2**REG_AW  scoreboard pending bits
load_timeout  out  1  sticky timeout error
timeout_rd  out  REG_AW  register of the first timeout
cnt_bypass, cnt_ret_fwd, cnt_stall  out  CNT_W each  performance counters

Behaviour:
Reset values:
- pending_vec=0, all timers=0, load_timeout=0, timeout_rd=0, counters=0.
- Combinational outputs follow their inputs from reset state.

Operand resolution (combinational, zero latency, per operand i):
- If !dec_valid or src==0: sel=0, data=rf_data, no stall.
- Priority order:
  1. ld_ret_valid && ld_ret_rd==src -> sel=1.
  2. Bypass lanes, stage 0 first; within a stage, lowest lane index wins.
  3. RF.
- stall_src[i] = dec_valid && src!=0 && pending[src] && !(ld_ret_valid && ld_ret_rd==src). A bypass hit does not clear a pending hazard.
- When stall_src[i]=1: sel=0 and data=rf_data (don't-care for the consumer).

Scoreboard (sequential, one entry per register):
- ld_issue_ready = !flush && (!pending[ld_issue_rd] || (ld_ret_valid && ld_ret_rd==ld_issue_rd)).
- Issue accepted = ld_issue_valid && ld_issue_ready && ld_issue_rd!=0. An issue to r0 is ignored and never sets pending.
- Accepted issue: pending[rd]<=1 and timer[rd]<=LOAD_TIMEOUT on the next edge. Issue wins over a same-cycle return to the same register.
- Return: clears pending[rd] and timer[rd]. A return to a non-pending register is ignored.
- Each cycle, every pending timer decrements.
- Timer==1 with no same-cycle return:
  - pending cleared;
  - load_timeout set;
  - timeout_rd captured, first occurrence only. If several registers expire in the same cycle, the lowest index is captured.
  - load_timeout is cleared only by reset.
- flush: clears all pending bits and timers next edge; same-cycle issue is dropped (ready=0); flush has no effect on load_timeout or the counters.
- Reset mid-load: scoreboard empties asynchronously; a later return is ignored.

Counters (saturate at all-ones, update only when dec_valid && !stall):
- cnt_bypass: +1 if any operand sel>=2.
- cnt_ret_fwd: +1 if any operand sel==1.
- cnt_stall: +1 each cycle with dec_valid && stall (this one counts on stall cycles instead).

Decomposition:
- Shared package vtx1_fwd_pkg: FWD_SEL_RF=0 and FWD_SEL_RET=1 constants, SEL_W helper function, bypass index function s*NUM_LANES+l.
- One natural sub-module: fwd_operand_mux, the per-operand priority selector, instantiated NUM_SRC times via generate. Scoreboard, timers and counters stay in the top module.

Test Plan:
- Basic bypass: src={5,6,0}; stage0 lane1 rd=5 data=0xAAAA; stage1 lane0 rd=6 data=0xBBBB -> fwd_sel={3,4,0}, data {0xAAAA,0xBBBB,rf}, stall=0, cnt_bypass +1.
- Bypass priority: stage0 lanes 0 and 1 plus stage1 lane0 all write r7; src0=7 -> sel=2, stage0 lane0 data.
- Load stall and return forward: issue r9 at cycle 0. Cycle 1, src0=9 -> stall=1, cnt_stall=1. Cycle 3, ld_ret r9 data=0x1234 -> stall=0, sel=1, data=0x1234; pending_vec[9]=0 at cycle 4.
- Re-issue and r0:
  - Issue r9 while r9 pending, no return -> ld_issue_ready=0.
  - Same cycle as return r9 -> ready=1, pending stays 1, timer reloaded.
  - Issue r0 -> pending_vec unchanged.
- Timeout: LOAD_TIMEOUT=4, issue r12, no return -> pending[12] clears on the 4th edge after issue; load_timeout=1; timeout_rd=12; stays set after a later flush.
- Flush and counter saturation:
  - Flush with r3 and r4 pending plus a simultaneous issue of r5 -> pending_vec=0 next cycle.
  - CNT_W=4, 20 bypass cycles -> cnt_bypass=15.
